mips_multicycle_ctrl: RTL

- Multi-cycle MIPS control unit. Sequences the shared datapath (instrMem/unified memory port, signExtend, shiftLeft2, Mux21 selects, ALU, register file, PC) through fetch, decode, execute, memory and writeback.
- One instruction in flight at a time. Memory accesses stall on a ready handshake.
- Also flags illegal opcodes and counts retired instructions.

---
 rtl/mips_multicycle_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// flags unsupported opcodes and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t st;
    state_t st_nx;
    logic   retire;
    logic   bad_op;

    logic is_r;
    logic is_j;
    logic is_beq;
    logic is_addi;
    logic is_lw;
    logic is_sw;

    assign is_r    = (opcode == 6'h00);
    assign is_j    = (opcode == 6'h02);
    assign is_beq  = (opcode == 6'h04);
    assign is_addi = (opcode == 6'h08);
    assign is_lw   = (opcode == 6'h23);
    assign is_sw   = (opcode == 6'h2B);

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            st      <= st_nx;
            illegal <= bad_op;
        end
    end

    // Saturating counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire && (retired != '1)) begin
            retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        st_nx      = st;
        retire     = 1'b0;
        bad_op     = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        // Everything stays at 0 while reset is held.
        if (rst_n) begin
            unique case (st)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) st_nx = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    unique case (1'b1)
                        is_lw, is_sw: st_nx = S_MEMADR;
                        is_r:         st_nx = S_EXEC;
                        is_beq:       st_nx = S_BRANCH;
                        is_addi:      st_nx = S_ADDIEX;
                        is_j:         st_nx = S_JUMP;
                        default: begin
                            st_nx  = S_FETCH;
                            bad_op = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    st_nx     = is_sw ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) st_nx = S_MEMWB;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                    st_nx      = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    retire    = mem_ready;
                    if (mem_ready) st_nx = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    st_nx     = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    st_nx     = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                    retire    = 1'b1;
                    st_nx     = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    st_nx     = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    st_nx     = S_FETCH;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    st_nx    = S_FETCH;
                end
                default: st_nx = S_FETCH;
            endcase
        end
    end

endmodule
